// File: rtl/demux_1to8_stream.sv
// rtl/demux_1to8_stream.sv - registered 1-to-8 valid/ready stream demultiplexer
// Optional round-robin steering via DEMUX_1TO8_STREAM_RR_EN (adds rr_mode port).
module demux_1to8_stream #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef DEMUX_1TO8_STREAM_RR_EN
  input  logic                 rr_mode,
`endif
  output logic [8*WIDTH-1:0]   out_data,
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic                 ch_busy
);

  logic [2:0] dst;
  logic       accept;

`ifdef DEMUX_1TO8_STREAM_RR_EN
  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    dst   = rr_mode ? ptr_q : in_sel;
    // Pointer only advances on accepts made while round-robin steering is active.
    if (accept && rr_mode) begin
      ptr_d = ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    dst = in_sel;
  end
`endif

  // A full slot that drains this cycle can take the next beat with no bubble.
  assign in_ready = !out_valid[dst] || out_ready[dst];
  assign accept   = in_valid && in_ready;
  assign ch_busy  = |out_valid;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             load;

    always_comb begin
      load  = accept && (dst == 3'(k));
      vld_d = vld_q;
      dat_d = dat_q;
      if (load) begin
        vld_d = 1'b1;
        dat_d = in_data;
      end else if (out_ready[k]) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_valid[k]                 = vld_q;
    assign out_data[k*WIDTH +: WIDTH]   = dat_q;
  end

endmodule

// File: tb/tb_demux_1to8_stream.sv
// tb/tb_demux_1to8_stream.sv - scoreboard bench for demux_1to8_stream
module tb_demux_1to8_stream;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic        ch_busy;
`ifdef DEMUX_1TO8_STREAM_RR_EN
  logic        rr_mode;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  demux_1to8_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX_1TO8_STREAM_RR_EN
    .rr_mode   (rr_mode),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_busy   (ch_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // Present a beat, wait (bounded) for acceptance, record expectation on channel ch.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [2:0] ch);
    int n;
    n = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=%h exp=accepted", d);
    end else begin
      push(ch, d);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 8'hFF;
    repeat (2) step();
    out_ready = 8'h00;
  endtask

  // Monitor: every handshake on an output channel pops the oldest expectation for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].ch == 3'(k)) idx = i;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected ch=%0d act=%h exp=none", k, out_data[k*8 +: 8]);
          end else begin
            chk($sformatf("sb_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(exp_q[idx].d));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_sel    = 3'd0;
    in_valid  = 1'b0;
    out_ready = 8'h00;
`ifdef DEMUX_1TO8_STREAM_RR_EN
    rr_mode   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    chk("rst_valid", 64'(out_valid), 64'h00);
    chk("rst_busy", 64'(ch_busy), 64'h0);
    chk("rst_data", out_data, 64'h0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1 chk($sformatf("rst_ready_sel%0d", s), 64'(in_ready), 64'h1);
    end

    // Single beat and backpressure
    send(8'hA5, 3'd3, 3'd3);
    chk("single_valid", 64'(out_valid), 64'h08);
    chk("single_data", 64'(out_data[31:24]), 64'hA5);
    chk("single_busy", 64'(ch_busy), 64'h1);
    in_data = 8'h5C;
    in_sel  = 3'd3;
    #1 chk("bp_ready_novalid", 64'(in_ready), 64'h0);
    in_valid = 1'b1;
    #1 chk("bp_ready0", 64'(in_ready), 64'h0);
    in_sel = 3'd2;
    #1 chk("bp_other_sel_ready", 64'(in_ready), 64'h1);
    in_sel = 3'd3;
    step();
    chk("bp_ready1", 64'(in_ready), 64'h0);
    chk("bp_hold_valid", 64'(out_valid), 64'h08);
    chk("bp_hold_data", 64'(out_data[31:24]), 64'hA5);
    out_ready[3] = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'h1);
    push(3'd3, 8'h5C);
    step();
    in_valid  = 1'b0;
    out_ready = 8'h00;
    chk("bp_second_valid", 64'(out_valid), 64'h08);
    chk("bp_second_data", 64'(out_data[31:24]), 64'h5C);
    drain_all();
    chk("drained_valid", 64'(out_valid), 64'h00);

    // Pipe-through on a full, draining slot
    send(8'h11, 3'd5, 3'd5);
    chk("pipe_full", 64'(out_valid), 64'h20);
    out_ready[5] = 1'b1;
    in_data  = 8'h22;
    in_sel   = 3'd5;
    in_valid = 1'b1;
    #1 chk("pipe_ready", 64'(in_ready), 64'h1);
    push(3'd5, 8'h22);
    step();
    in_valid  = 1'b0;
    out_ready = 8'h00;
    chk("pipe_valid", 64'(out_valid), 64'h20);
    chk("pipe_data", 64'(out_data[47:40]), 64'h22);
    drain_all();

    // Independence: ch0 stalled, stream to 1..7 back-to-back
    send(8'hC3, 3'd0, 3'd0);
    in_valid = 1'b1;
    for (int s = 1; s < 8; s++) begin
      in_data = 8'(s);
      in_sel  = 3'(s);
      #1 chk($sformatf("indep_ready%0d", s), 64'(in_ready), 64'h1);
      push(3'(s), 8'(s));
      step();
    end
    in_valid = 1'b0;
    chk("indep_valid", 64'(out_valid), 64'hFF);
    chk("indep_data", out_data, 64'h07060504030201C3);
    drain_all();

    // Async reset mid-operation
    send(8'h31, 3'd1, 3'd1);
    send(8'h33, 3'd3, 3'd3);
    send(8'h34, 3'd4, 3'd4);
    send(8'h36, 3'd6, 3'd6);
    chk("pre_rst_valid", 64'(out_valid), 64'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h00);
    chk("async_rst_data", out_data, 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h1);
    exp_q.delete();
    #3 rst_n = 1'b1;
    step();

`ifdef DEMUX_1TO8_STREAM_RR_EN
    // Round-robin: 10 beats with in_sel fixed at 0
    rr_mode   = 1'b1;
    out_ready = 8'hFF;
    in_sel    = 3'd0;
    for (int i = 0; i < 10; i++) send(8'(i), 3'd0, 3'(i % 8));
    repeat (2) step();
    out_ready = 8'h00;
    send(8'hEE, 3'd0, 3'd2);
    chk("rr_ptr2", 64'(out_valid), 64'h04);
    rr_mode = 1'b0;
    drain_all();
`endif

    repeat (2) step();
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
